ps2_keycode_rx: RTL and testbench
=================================

# ps2_keycode_rx

PS/2 keyboard receiver that decodes the device-to-host serial stream (scan code set 2) into the same 8-bit USB HID usage keycode the game logic already consumes from the USB host system. It is a drop-in alternative keycode source: its `keycode` output feeds the ball and game blocks directly, with no Nios II software involved. It handles make, break and extended (E0) prefixes, and reports framing and parity errors.

## Interface
- `FILTER_LEN`, 8: cycles `ps2_clk` must hold a new level before the filter accepts it.
- `TIMEOUT_CYCLES`, 50000: idle `Clk` cycles (1 ms at 50 MHz) after which a partial frame is abandoned.
- `Clk`  in  1  50 MHz system clock; the only clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock from the keyboard; asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the keyboard; asynchronous.
- `keycode`  out  8  HID usage of the key currently held; 0x00 when no mapped key is held.
- `key_valid`  out  1  one-cycle pulse on every `keycode` update, including updates to 0x00.
- `frame_err`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- Both raw inputs pass through 2-flop synchronizers. `ps2_clk` then passes through a stable-level filter of length `FILTER_LEN`. `ps2_data` is sampled on each filtered `ps2_clk` falling edge.
- Frame layout is 11 bits: start=0, D0..D7 (LSB first), odd parity, stop=1.
- FSM states are IDLE, DATA, PARITY and STOP.
  - IDLE: on a falling edge with data=0, go to DATA with bit count 0. If data=1, stay in IDLE silently.
  - DATA: shift in 8 bits, then go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: require stop=1 and odd parity over D0..D7 plus the parity bit. Either failure pulses `frame_err`, discards the byte, clears the prefix flags, and returns to IDLE.
- Accepted byte B:
  - B=0xE0 sets `ext`. B=0xF0 sets `brk`. Neither changes `keycode`.
  - Any other byte is mapped to HID usage U through the table below, using `ext`, and then both flags clear.
  - Make with U≠0: `keycode`←U and `key_valid` pulses.
  - Break with U equal to the current `keycode`: `keycode`←0x00 and `key_valid` pulses.
  - Break of any other key, or U=0: no output change and no pulse.
- Mapping table (set 2 → HID):
  - 1D→1A (W), 1C→04 (A), 1B→16 (S), 23→07 (D)
  - 29→2C (space), 5A→28 (enter)
  - E0 75→52 (up), E0 72→51 (down), E0 6B→50 (left), E0 74→4F (right)
  - All other codes map to 00.
- Timeout: in any state other than IDLE, if `TIMEOUT_CYCLES` elapse with no filtered falling edge, return to IDLE, clear the prefix flags, and pulse `frame_err`. The timeout counter resets on each falling edge.
- Reset asserted at any time, including mid-frame: the FSM goes to IDLE, flags clear, and all outputs return to their reset values immediately.

## Timing
- Reset values: `keycode`=0x00, `key_valid`=0, `frame_err`=0. The synchronizers and filter reset to the idle line level (1).
- Edge-to-sample latency is 2 synchronizer cycles plus `FILTER_LEN` plus 1 edge-detect cycle.
- Latency from the stop-bit falling edge to the `key_valid`/`frame_err` pulse is 1 `Clk` cycle. `keycode` is updated in the same cycle that `key_valid` is high.
- `key_valid` and `frame_err` are never high in the same cycle.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no edge.
- A keyboard clock of 10–16.7 kHz is supported with a 50 MHz `Clk`.

## Structure
- Package `ps2_pkg` holds:
  - the `ps2_state_t` enum (IDLE, DATA, PARITY, STOP);
  - the prefix constants E0 and F0;
  - the HID keycode constants shared with the ball logic (W/A/S/D/arrows/space/enter).
- Sub-module `ps2_clk_filter`: synchronizer, stable-level filter and falling-edge pulse generator, with parameter `FILTER_LEN`.
- The mapping is a combinational case statement inside `ps2_keycode_rx`.

## Test plan
- Reset then idle lines: `keycode`=0x00, and there are no pulses for 10 ms.
- Frame 0x1D with good parity: `keycode`=0x1A and one `key_valid` pulse. Then F0 1D: `keycode`=0x00 and one more pulse.
- E0 75 followed by E0 F0 75: `keycode` goes 0x52 then 0x00. No pulse occurs on the E0 or F0 bytes.
- Press 0x1C, press 0x23, then release 0x1C: `keycode` goes 0x04, then 0x07, and stays 0x07 with no pulse on the release.
- Errors:
  - A frame with wrong parity gives one `frame_err` pulse and `keycode` unchanged.
  - A stop bit of 0 gives one `frame_err` pulse.
  - Stopping the clock after 5 bits gives `frame_err` 1 ms later. A following good 0x29 frame then yields 0x2C.
- Robustness:
  - 3-cycle glitches on `ps2_clk` during a 0x1B frame still decode to 0x16.
  - Asserting `Reset` mid-frame returns `keycode` to 0x00. The next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: FSM state
// encoding, set-2 prefix bytes and the HID usages the ball/game logic uses.
package ps2_pkg;

  // Receiver frame state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Scan code set 2 prefix bytes
  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  // Set 2 make codes that the game cares about
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;  // E0-prefixed
  localparam logic [7:0] SC_DOWN  = 8'h72;  // E0-prefixed
  localparam logic [7:0] SC_LEFT  = 8'h6B;  // E0-prefixed
  localparam logic [7:0] SC_RIGHT = 8'h74;  // E0-prefixed

  // HID usage codes shared with the ball logic
  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_ENTER = 8'h28;
  localparam logic [7:0] HID_UP    = 8'h52;
  localparam logic [7:0] HID_DOWN  = 8'h51;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_RIGHT = 8'h4F;

  // Odd parity holds when D0..D7 plus the parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the raw PS/2 clock, accepts a new level only after it has been
// stable for FILTER_LEN cycles, and emits a one-cycle pulse on each accepted
// falling edge.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  output logic ps2_fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       sync_reg;
  logic             filt_reg;
  logic             filt_d_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Two-flop synchronizer; resets to the idle line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], ps2_clk};
    end
  end

  // Stable-level filter: a differing level must persist FILTER_LEN cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_reg <= 1'b1;
      cnt_reg  <= '0;
    end else if (sync_reg[1] == filt_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      filt_reg <= sync_reg[1];
      cnt_reg  <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Delayed copy of the filtered level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_d_reg <= 1'b1;
    end else begin
      filt_d_reg <= filt_reg;
    end
  end

  assign ps2_fall = filt_d_reg & ~filt_reg;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: deserializes set-2 frames, tracks E0/F0 prefixes
// and presents the held key as an 8-bit HID usage for the game logic.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       state_reg;
  logic [1:0]       data_sync_reg;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_cnt_reg;
  logic             parity_reg;
  logic             ext_reg;
  logic             brk_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic [7:0]       keycode_reg;
  logic             key_valid_reg;
  logic             frame_err_reg;

  logic             fall;
  logic             data_bit;
  logic [7:0]       usage_next;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk      (Clk),
    .rst_n    (Reset),
    .ps2_clk  (ps2_clk),
    .ps2_fall (fall)
  );

  // Two-flop synchronizer for the data line; resets to idle level
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      data_sync_reg <= 2'b11;
    end else begin
      data_sync_reg <= {data_sync_reg[0], ps2_data};
    end
  end

  assign data_bit = data_sync_reg[1];

  // Set-2 to HID translation of the just-completed byte, honouring the E0 prefix
  always_comb begin
    usage_next = HID_NONE;
    if (ext_reg) begin
      case (shift_reg)
        SC_UP:    usage_next = HID_UP;
        SC_DOWN:  usage_next = HID_DOWN;
        SC_LEFT:  usage_next = HID_LEFT;
        SC_RIGHT: usage_next = HID_RIGHT;
        default:  usage_next = HID_NONE;
      endcase
    end else begin
      case (shift_reg)
        SC_W:     usage_next = HID_W;
        SC_A:     usage_next = HID_A;
        SC_S:     usage_next = HID_S;
        SC_D:     usage_next = HID_D;
        SC_SPACE: usage_next = HID_SPACE;
        SC_ENTER: usage_next = HID_ENTER;
        default:  usage_next = HID_NONE;
      endcase
    end
  end

  // Frame FSM with prefix tracking, key state and registered pulse outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      parity_reg    <= 1'b0;
      ext_reg       <= 1'b0;
      brk_reg       <= 1'b0;
      tmo_cnt_reg   <= '0;
      keycode_reg   <= HID_NONE;
      key_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      key_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;

      // Idle-time counter only runs mid-frame and restarts on every edge
      if (fall || state_reg == IDLE) begin
        tmo_cnt_reg <= '0;
      end else begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end

      if (state_reg != IDLE && !fall && tmo_cnt_reg == TMO_LAST) begin
        // Keyboard stalled mid-frame: abandon the partial byte
        state_reg     <= IDLE;
        ext_reg       <= 1'b0;
        brk_reg       <= 1'b0;
        frame_err_reg <= 1'b1;
      end else if (fall) begin
        case (state_reg)
          IDLE: begin
            // A high level here is line noise, not a start bit
            if (!data_bit) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end
          end
          DATA: begin
            shift_reg   <= {data_bit, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= PARITY;
            end
          end
          PARITY: begin
            parity_reg <= data_bit;
            state_reg  <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
            if (!data_bit || !odd_parity_ok(shift_reg, parity_reg)) begin
              frame_err_reg <= 1'b1;
              ext_reg       <= 1'b0;
              brk_reg       <= 1'b0;
            end else if (shift_reg == PREFIX_EXT) begin
              ext_reg <= 1'b1;
            end else if (shift_reg == PREFIX_BRK) begin
              brk_reg <= 1'b1;
            end else begin
              ext_reg <= 1'b0;
              brk_reg <= 1'b0;
              if (usage_next != HID_NONE) begin
                if (!brk_reg) begin
                  keycode_reg   <= usage_next;
                  key_valid_reg <= 1'b1;
                end else if (usage_next == keycode_reg) begin
                  // Only releasing the reported key clears it
                  keycode_reg   <= HID_NONE;
                  key_valid_reg <= 1'b1;
                end
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign keycode   = keycode_reg;
  assign key_valid = key_valid_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: drives PS/2 frames with hand-computed
// expected keycodes and counts key_valid / frame_err pulses.
module tb_ps2_keycode_rx;

  localparam int HALF    = 20;    // PS/2 half period in Clk cycles
  localparam int TIMEOUT = 1000;  // shortened abandon time for simulation

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_err;

  int n_checks = 0;
  int n_pass   = 0;
  int kv_cnt   = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;

  ps2_keycode_rx #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always #10 Clk = ~Clk;

  // Pulse counters sampled away from the active edge
  always @(negedge Clk) begin
    if (key_valid) kv_cnt++;
    if (frame_err) fe_cnt++;
    if (key_valid && frame_err) both_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s: 0x%0h ok", tag, got);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One bit cell: data set while clock high, falling edge mid-cell
  task automatic send_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      idle(5);  ps2_clk = 1'b0;
      idle(3);  ps2_clk = 1'b1;
      idle(HALF - 8);
    end else begin
      idle(HALF);
    end
    ps2_clk = 1'b0;
    if (glitch) begin
      idle(12); ps2_clk = 1'b1;
      idle(3);  ps2_clk = 1'b0;
      idle(HALF - 15);
    end else begin
      idle(HALF);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit,
                            input logic glitch);
    logic par;
    par = (~^b) ^ bad_par;
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(par, glitch);
    send_bit(stop_bit, glitch);
    ps2_data = 1'b1;
    idle(40);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 1'b0);
  endtask

  // Start bit plus (nbits-1) data bits, then the keyboard goes silent
  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits - 1; i++) send_bit(b[i], 1'b0);
    ps2_data = 1'b1;
  endtask

  initial begin
    // Reset and idle lines
    idle(3);
    check_val("reset_keycode", {24'd0, keycode}, 32'h00);
    idle(2);
    Reset = 1'b1;
    idle(2000);
    check_val("idle_kv_pulses", kv_cnt, 0);
    check_val("idle_fe_pulses", fe_cnt, 0);

    // W make and break
    send_byte(8'h1D);
    check_val("w_make_key", {24'd0, keycode}, 32'h1A);
    check_val("w_make_kv", kv_cnt, 1);
    send_byte(8'hF0);
    send_byte(8'h1D);
    check_val("w_break_key", {24'd0, keycode}, 32'h00);
    check_val("w_break_kv", kv_cnt, 2);

    // Extended up-arrow make and break
    send_byte(8'hE0);
    check_val("e0_no_pulse", kv_cnt, 2);
    send_byte(8'h75);
    check_val("up_make_key", {24'd0, keycode}, 32'h52);
    check_val("up_make_kv", kv_cnt, 3);
    send_byte(8'hE0);
    send_byte(8'hF0);
    check_val("e0f0_no_pulse", kv_cnt, 3);
    send_byte(8'h75);
    check_val("up_break_key", {24'd0, keycode}, 32'h00);
    check_val("up_break_kv", kv_cnt, 4);

    // Rollover: release of a key that is no longer reported is ignored
    send_byte(8'h1C);
    check_val("a_make_key", {24'd0, keycode}, 32'h04);
    send_byte(8'h23);
    check_val("d_make_key", {24'd0, keycode}, 32'h07);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check_val("a_rel_key", {24'd0, keycode}, 32'h07);
    check_val("a_rel_kv", kv_cnt, 6);

    // Wrong parity
    send_frame(8'h1B, 1'b1, 1'b1, 1'b0);
    check_val("par_err_fe", fe_cnt, 1);
    check_val("par_err_key", {24'd0, keycode}, 32'h07);

    // Stop bit of 0
    send_frame(8'h1D, 1'b0, 1'b0, 1'b0);
    check_val("stop_err_fe", fe_cnt, 2);
    check_val("stop_err_key", {24'd0, keycode}, 32'h07);

    // Error must drop a pending break prefix: following 0x23 is a make
    send_byte(8'hF0);
    send_frame(8'h23, 1'b1, 1'b1, 1'b0);
    send_byte(8'h23);
    check_val("err_clr_fe", fe_cnt, 3);
    check_val("err_clr_key", {24'd0, keycode}, 32'h07);
    check_val("err_clr_kv", kv_cnt, 7);

    // Stall after 5 bits, then recover with space
    send_partial(8'h29, 5);
    idle(TIMEOUT / 2);
    check_val("tmo_early_fe", fe_cnt, 3);
    idle(TIMEOUT / 2 + 200);
    check_val("tmo_fe", fe_cnt, 4);
    check_val("tmo_key", {24'd0, keycode}, 32'h07);
    send_byte(8'h29);
    check_val("space_key", {24'd0, keycode}, 32'h2C);
    check_val("space_kv", kv_cnt, 8);

    // Short glitches on ps2_clk throughout an S frame
    send_frame(8'h1B, 1'b0, 1'b1, 1'b1);
    check_val("glitch_key", {24'd0, keycode}, 32'h16);
    check_val("glitch_kv", kv_cnt, 9);
    check_val("glitch_fe", fe_cnt, 4);

    // Reset mid-frame, then a clean enter frame
    send_partial(8'h5A, 4);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check_val("midrst_key", {24'd0, keycode}, 32'h00);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    idle(20);
    Reset = 1'b1;
    idle(20);
    send_byte(8'h5A);
    check_val("enter_key", {24'd0, keycode}, 32'h28);
    check_val("enter_kv", kv_cnt, 10);
    check_val("enter_fe", fe_cnt, 4);

    check_val("kv_fe_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
